// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
package regfile_pkg;

   localparam int DATA_W   = 64;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = $clog2(NUM_REGS);
   localparam int ZERO_REG = 31;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Register file access bundle: one write port, two read ports.
// master = datapath side, slave = register file side.
interface reg_file_2r1w_if;
   import regfile_pkg::*;

   logic      reg_write;
   reg_addr_t write_reg;
   reg_data_t write_data;
   reg_addr_t read_reg1;
   reg_addr_t read_reg2;
   reg_data_t read_data1;
   reg_data_t read_data2;

   modport master (
      output reg_write,
      output write_reg,
      output write_data,
      output read_reg1,
      output read_reg2,
      input  read_data1,
      input  read_data2
   );

   modport slave (
      input  reg_write,
      input  write_reg,
      input  write_data,
      input  read_reg1,
      input  read_reg2,
      output read_data1,
      output read_data2
   );

endinterface

// File: rtl/reg_file_2r1w_register_en.sv
// DATA_W-bit storage register with load enable and synchronous active-low reset.
// When not enabled the flops recirculate their own output; no clock gating.
module register_en
   import regfile_pkg::*;
(
   input  logic      clk,
   input  logic      reset_n,
   input  logic      en,
   input  reg_data_t d,
   output reg_data_t q
);

   // Clear on reset, otherwise select between new data and held value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q <= '0;
      end else begin
         q <= en ? d : q;
      end
   end

endmodule

// File: rtl/reg_file_2r1w.sv
// NUM_REGS x DATA_W register file, one synchronous write port and two
// combinational read ports. Register ZERO_REG is hardwired to zero: it has
// no storage and no write enable. There is no write-to-read bypass; a read
// of the address being written sees the old value until the clock edge.
module reg_file_2r1w
   import regfile_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   reg_file_2r1w_if.slave   bus
);

   // Storage plus one-hot write decode, one slice per register.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      reg_data_t q;

      if (i == ZERO_REG) begin : g_zero
         // Decoder output for this index is masked by construction.
         assign q = '0;
      end else begin : g_store
         logic en;

         // Per-register write enable from the gated address decoder.
         assign en = bus.reg_write && (bus.write_reg == reg_addr_t'(i));

         register_en u_reg (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en),
            .d       (bus.write_data),
            .q       (q)
         );
      end
   end

   // Read mux trees: level l halves the candidates using address bit l-1.
   for (genvar l = 0; l <= ADDR_W; l++) begin : g_lvl
      localparam int N = NUM_REGS >> l;
      reg_data_t p1 [N];
      reg_data_t p2 [N];

      if (l == 0) begin : g_leaf
         for (genvar i = 0; i < N; i++) begin : g_in
            assign p1[i] = g_reg[i].q;
            assign p2[i] = g_reg[i].q;
         end
      end else begin : g_node
         for (genvar i = 0; i < N; i++) begin : g_mux
            assign p1[i] = bus.read_reg1[l-1] ? g_lvl[l-1].p1[2*i+1] : g_lvl[l-1].p1[2*i];
            assign p2[i] = bus.read_reg2[l-1] ? g_lvl[l-1].p2[2*i+1] : g_lvl[l-1].p2[2*i];
         end
      end
   end

   assign bus.read_data1 = g_lvl[ADDR_W].p1[0];
   assign bus.read_data2 = g_lvl[ADDR_W].p2[0];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w.
module tb_reg_file_2r1w;
   import regfile_pkg::*;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   reg_file_2r1w_if bus ();

   reg_file_2r1w dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.reg_write  = 1'b0;
      bus.write_reg  = '0;
      bus.write_data = '0;
      bus.read_reg1  = '0;
      bus.read_reg2  = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      bus.reg_write  = 1'b1;
      bus.write_reg  = reg_addr_t'(5);
      bus.write_data = 64'hDEAD_BEEF_CAFE_F00D;
      tick();
      bus.reg_write = 1'b0;
      bus.read_reg1 = reg_addr_t'(5);
      #1;
      checks++;
      if (bus.read_data1 !== 64'hDEAD_BEEF_CAFE_F00D) begin
         failures++;
         $display("FAIL reset_prewrite x5 got=%h exp=%h", bus.read_data1, 64'hDEAD_BEEF_CAFE_F00D);
      end
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      bus.read_reg1 = reg_addr_t'(5);
      bus.read_reg2 = reg_addr_t'(0);
      #1;
      checks++;
      if (bus.read_data1 !== 64'h0) begin
         failures++;
         $display("FAIL reset_x5 got=%h exp=%h", bus.read_data1, 64'h0);
      end
      checks++;
      if (bus.read_data2 !== 64'h0) begin
         failures++;
         $display("FAIL reset_x0 got=%h exp=%h", bus.read_data2, 64'h0);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         bus.read_reg1 = reg_addr_t'(i);
         bus.read_reg2 = reg_addr_t'(NUM_REGS - 1 - i);
         #1;
         checks++;
         if (bus.read_data1 !== 64'h0 || bus.read_data2 !== 64'h0) begin
            failures++;
            $display("FAIL reset_all addr=%0d got1=%h got2=%h exp=0", i, bus.read_data1, bus.read_data2);
         end
      end
   endtask

   task automatic test_write_readback();
      for (int i = 0; i <= 30; i++) begin
         bus.reg_write  = 1'b1;
         bus.write_reg  = reg_addr_t'(i);
         bus.write_data = 64'h0000_0000_0000_0100 + 64'(i);
         tick();
      end
      bus.reg_write = 1'b0;
      for (int i = 0; i <= 30; i++) begin
         bus.read_reg1 = reg_addr_t'(i);
         bus.read_reg2 = reg_addr_t'(30 - i);
         #1;
         checks++;
         if (bus.read_data1 !== 64'h100 + 64'(i)) begin
            failures++;
            $display("FAIL readback_p1 addr=%0d got=%h exp=%h", i, bus.read_data1, 64'h100 + 64'(i));
         end
         checks++;
         if (bus.read_data2 !== 64'h100 + 64'(30 - i)) begin
            failures++;
            $display("FAIL readback_p2 addr=%0d got=%h exp=%h", 30 - i, bus.read_data2, 64'h100 + 64'(30 - i));
         end
      end
   endtask

   task automatic test_zero_reg();
      bus.reg_write  = 1'b1;
      bus.write_reg  = reg_addr_t'(31);
      bus.write_data = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      bus.reg_write = 1'b0;
      bus.read_reg1 = reg_addr_t'(31);
      bus.read_reg2 = reg_addr_t'(31);
      #1;
      checks++;
      if (bus.read_data1 !== 64'h0) begin
         failures++;
         $display("FAIL zero_p1 got=%h exp=%h", bus.read_data1, 64'h0);
      end
      checks++;
      if (bus.read_data2 !== 64'h0) begin
         failures++;
         $display("FAIL zero_p2 got=%h exp=%h", bus.read_data2, 64'h0);
      end
      bus.read_reg1 = reg_addr_t'(30);
      #1;
      checks++;
      if (bus.read_data1 !== 64'h11E) begin
         failures++;
         $display("FAIL zero_x30_intact got=%h exp=%h", bus.read_data1, 64'h11E);
      end
   endtask

   task automatic test_enable_low();
      bus.reg_write  = 1'b0;
      bus.write_reg  = reg_addr_t'(7);
      bus.write_data = 64'h1234;
      tick();
      tick();
      tick();
      bus.read_reg1 = reg_addr_t'(7);
      bus.read_reg2 = reg_addr_t'(7);
      #1;
      checks++;
      if (bus.read_data1 !== 64'h107) begin
         failures++;
         $display("FAIL enable_low_x7 got=%h exp=%h", bus.read_data1, 64'h107);
      end
      checks++;
      if (bus.read_data2 !== 64'h107) begin
         failures++;
         $display("FAIL enable_low_x7_p2 got=%h exp=%h", bus.read_data2, 64'h107);
      end
   endtask

   task automatic test_collision();
      bus.read_reg1  = reg_addr_t'(12);
      bus.read_reg2  = reg_addr_t'(13);
      bus.write_reg  = reg_addr_t'(12);
      bus.write_data = 64'hA5A5_A5A5_A5A5_A5A5;
      bus.reg_write  = 1'b1;
      #1;
      checks++;
      if (bus.read_data1 !== 64'h10C) begin
         failures++;
         $display("FAIL collision_before got=%h exp=%h", bus.read_data1, 64'h10C);
      end
      tick();
      bus.reg_write = 1'b0;
      checks++;
      if (bus.read_data1 !== 64'hA5A5_A5A5_A5A5_A5A5) begin
         failures++;
         $display("FAIL collision_after got=%h exp=%h", bus.read_data1, 64'hA5A5_A5A5_A5A5_A5A5);
      end
      checks++;
      if (bus.read_data2 !== 64'h10D) begin
         failures++;
         $display("FAIL collision_x13 got=%h exp=%h", bus.read_data2, 64'h10D);
      end
   endtask

   task automatic test_reset_vs_write();
      bus.read_reg1 = reg_addr_t'(3);
      bus.read_reg2 = reg_addr_t'(4);
      #1;
      checks++;
      if (bus.read_data1 !== 64'h103) begin
         failures++;
         $display("FAIL rst_vs_wr_pre x3 got=%h exp=%h", bus.read_data1, 64'h103);
      end
      reset_n        = 1'b0;
      bus.reg_write  = 1'b1;
      bus.write_reg  = reg_addr_t'(3);
      bus.write_data = 64'h55;
      tick();
      reset_n       = 1'b1;
      bus.reg_write = 1'b0;
      #1;
      checks++;
      if (bus.read_data1 !== 64'h0) begin
         failures++;
         $display("FAIL rst_vs_wr_x3 got=%h exp=%h", bus.read_data1, 64'h0);
      end
      checks++;
      if (bus.read_data2 !== 64'h0) begin
         failures++;
         $display("FAIL rst_vs_wr_x4 got=%h exp=%h", bus.read_data2, 64'h0);
      end
   endtask

   task automatic test_back_to_back();
      bus.reg_write  = 1'b1;
      bus.write_reg  = reg_addr_t'(9);
      bus.write_data = 64'h1111;
      tick();
      bus.write_reg  = reg_addr_t'(10);
      bus.write_data = 64'h2222;
      tick();
      bus.write_reg  = reg_addr_t'(9);
      bus.write_data = 64'h3333;
      tick();
      bus.reg_write = 1'b0;
      bus.read_reg1 = reg_addr_t'(9);
      bus.read_reg2 = reg_addr_t'(10);
      #1;
      checks++;
      if (bus.read_data1 !== 64'h3333) begin
         failures++;
         $display("FAIL b2b_x9 got=%h exp=%h", bus.read_data1, 64'h3333);
      end
      checks++;
      if (bus.read_data2 !== 64'h2222) begin
         failures++;
         $display("FAIL b2b_x10 got=%h exp=%h", bus.read_data2, 64'h2222);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      test_reset();
      test_write_readback();
      test_zero_reg();
      test_enable_low();
      test_collision();
      test_reset_vs_write();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
